// File: rtl/simd_sdiv_seq.sv
// Signed element-wise vector DIV/REM sequencer around an unsigned SIMD divider.
// A single external negation unit is time-shared for |a|, |b| and result sign fix-up.
module simd_sdiv_seq #(
  parameter int MIN_WIDTH = 8,
  parameter int MAX_WIDTH = 64,
  parameter int RATIO     = MAX_WIDTH / MIN_WIDTH,
  parameter int SEW_WIDTH = $clog2(RATIO) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_op,
  input  logic [SEW_WIDTH-1:0] in_sew,
  input  logic [MAX_WIDTH-1:0] in_a,
  input  logic [MAX_WIDTH-1:0] in_b,
  output logic [MAX_WIDTH-1:0] neg_opA,
  output logic [SEW_WIDTH-1:0] neg_sew,
  output logic [RATIO-1:0]     neg_change,
  input  logic [MAX_WIDTH-1:0] neg_result,
  output logic                 div_valid,
  input  logic                 div_ready,
  output logic [MAX_WIDTH-1:0] div_a,
  output logic [MAX_WIDTH-1:0] div_b,
  output logic [SEW_WIDTH-1:0] div_sew,
  output logic                 div_rem,
  input  logic                 div_done,
  input  logic [MAX_WIDTH-1:0] div_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAX_WIDTH-1:0] out_data,
  output logic                 out_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_NEG_A    = 3'd1,
    S_NEG_B    = 3'd2,
    S_DIV_REQ  = 3'd3,
    S_DIV_WAIT = 3'd4,
    S_NEG_R    = 3'd5,
    S_OUT      = 3'd6
  } state_t;

  // One bit per chunk that holds the sign bit of an element (top chunk of each element).
  function automatic logic [RATIO-1:0] top_mask(input logic [SEW_WIDTH-1:0] sew);
    logic [RATIO-1:0] m;
    m = '0;
    for (int k = 0; k < SEW_WIDTH; k++) begin
      if (sew[k]) begin
        for (int c = 0; c < RATIO; c++) begin
          if ((c % (RATIO >> k)) == ((RATIO >> k) - 1)) begin
            m[c] = 1'b1;
          end
        end
      end
    end
    return m;
  endfunction

  function automatic logic [RATIO-1:0] sign_mask(input logic [MAX_WIDTH-1:0] v,
                                                 input logic [RATIO-1:0] top);
    logic [RATIO-1:0] m;
    for (int c = 0; c < RATIO; c++) begin
      m[c] = v[c*MIN_WIDTH + MIN_WIDTH - 1] & top[c];
    end
    return m;
  endfunction

  // Flags zero elements, reported at the element's top chunk position.
  function automatic logic [RATIO-1:0] zero_mask(input logic [MAX_WIDTH-1:0] v,
                                                 input logic [SEW_WIDTH-1:0] sew);
    logic [RATIO-1:0] cz;
    logic [RATIO-1:0] m;
    logic             z;
    m = '0;
    for (int c = 0; c < RATIO; c++) begin
      cz[c] = (v[c*MIN_WIDTH +: MIN_WIDTH] == {MIN_WIDTH{1'b0}});
    end
    for (int k = 0; k < SEW_WIDTH; k++) begin
      if (sew[k]) begin
        for (int c = 0; c < RATIO; c++) begin
          if ((c % (RATIO >> k)) == ((RATIO >> k) - 1)) begin
            z = 1'b1;
            for (int j = 0; j < (RATIO >> k); j++) begin
              z = z & cz[c - j];
            end
            m[c] = z;
          end
        end
      end
    end
    return m;
  endfunction

  state_t                 state_q, state_d;
  logic [MAX_WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [SEW_WIDTH-1:0]   sew_q, sew_d;
  logic                   op_q, op_d, err_q, err_d;
  logic [RATIO-1:0]       ma_q, ma_d, mb_q, mb_d, mr_q, mr_d;

  logic [RATIO-1:0]       acc_top_s, acc_sa_s, acc_sb_s, acc_bz_s;
  logic                   acc_err_s;

  assign acc_top_s = top_mask(in_sew);
  assign acc_sa_s  = sign_mask(in_a, acc_top_s);
  assign acc_sb_s  = sign_mask(in_b, acc_top_s);
  assign acc_bz_s  = zero_mask(in_b, in_sew);
  assign acc_err_s = !$onehot(in_sew);

  // State and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sew_q   <= '0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      mr_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sew_q   <= sew_d;
      op_q    <= op_d;
      err_q   <= err_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      mr_q    <= mr_d;
    end
  end

  // Next state and datapath captures; NEG passes with an empty mask are bypassed.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sew_d   = sew_q;
    op_d    = op_q;
    err_d   = err_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    mr_d    = mr_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          op_d  = in_op;
          sew_d = in_sew;
          res_d = '0;
          err_d = acc_err_s;
          if (acc_err_s) begin
            ma_d    = '0;
            mb_d    = '0;
            mr_d    = '0;
            state_d = S_OUT;
          end else begin
            ma_d = acc_sa_s;
            mb_d = acc_sb_s;
            mr_d = in_op ? acc_sa_s : ((acc_sa_s ^ acc_sb_s) & ~acc_bz_s);
            if (|acc_sa_s) begin
              state_d = S_NEG_A;
            end else if (|acc_sb_s) begin
              state_d = S_NEG_B;
            end else begin
              state_d = S_DIV_REQ;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_NEG_A: begin
        a_d     = neg_result;
        state_d = (|mb_q) ? S_NEG_B : S_DIV_REQ;
      end
      S_NEG_B: begin
        b_d     = neg_result;
        state_d = S_DIV_REQ;
      end
      S_DIV_REQ: begin
        if (div_ready) begin
          state_d = S_DIV_WAIT;
        end else begin
          state_d = S_DIV_REQ;
        end
      end
      S_DIV_WAIT: begin
        if (div_done) begin
          res_d   = div_result;
          state_d = (|mr_q) ? S_NEG_R : S_OUT;
        end else begin
          state_d = S_DIV_WAIT;
        end
      end
      S_NEG_R: begin
        res_d   = neg_result;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    in_ready   = 1'b0;
    neg_opA    = '0;
    neg_sew    = '0;
    neg_change = '0;
    div_valid  = 1'b0;
    div_a      = '0;
    div_b      = '0;
    div_sew    = '0;
    div_rem    = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_err    = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_NEG_A: begin
        neg_opA    = a_q;
        neg_sew    = sew_q;
        neg_change = ma_q;
      end
      S_NEG_B: begin
        neg_opA    = b_q;
        neg_sew    = sew_q;
        neg_change = mb_q;
      end
      S_DIV_REQ: begin
        div_valid = 1'b1;
        div_a     = a_q;
        div_b     = b_q;
        div_sew   = sew_q;
        div_rem   = op_q;
      end
      S_NEG_R: begin
        neg_opA    = res_q;
        neg_sew    = sew_q;
        neg_change = mr_q;
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_data  = res_q;
        out_err   = err_q;
      end
      default: in_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_simd_sdiv_seq.sv
// Randomized self-checking bench for simd_sdiv_seq with behavioural negation unit,
// unsigned divider and a signed-arithmetic reference model.
module tb_simd_sdiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_op = 1'b0;
  logic [3:0]  in_sew = 4'd0;
  logic [63:0] in_a = 64'd0, in_b = 64'd0;
  logic [63:0] neg_opA, neg_result;
  logic [3:0]  neg_sew, div_sew;
  logic [7:0]  neg_change;
  logic        div_valid, div_ready, div_rem, div_done;
  logic [63:0] div_a, div_b, div_result, out_data;
  logic        out_valid, out_ready = 1'b0, out_err;

  int total = 0;
  int bad = 0;
  logic [63:0] last_data;

  int   div_dly = 1;
  logic div_ready_en = 1'b1;
  logic force_done = 1'b0;
  logic mdl_busy, mdl_done;
  int   mdl_cnt;
  logic [63:0] mdl_res;
  int   hs_cnt = 0;
  logic [63:0] hs_a, hs_b;
  logic [3:0]  hs_sew;
  logic        hs_rem;
  int   neg_cyc = 0;
  int   dv_cyc = 0;

  simd_sdiv_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_sew(in_sew), .in_a(in_a), .in_b(in_b), .neg_opA(neg_opA), .neg_sew(neg_sew),
    .neg_change(neg_change), .neg_result(neg_result), .div_valid(div_valid),
    .div_ready(div_ready), .div_a(div_a), .div_b(div_b), .div_sew(div_sew),
    .div_rem(div_rem), .div_done(div_done), .div_result(div_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] emask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic int sew_w(input logic [3:0] s);
    case (s)
      4'b0001: return 64;
      4'b0010: return 32;
      4'b0100: return 16;
      4'b1000: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] get_e(input logic [63:0] v, input int e, input int w);
    return (v >> (e * w)) & emask(w);
  endfunction

  function automatic logic [63:0] put_e(input logic [63:0] v, input int e, input int w,
                                        input logic [63:0] x);
    return (v & ~(emask(w) << (e * w))) | ((x & emask(w)) << (e * w));
  endfunction

  function automatic longint sext(input logic [63:0] v, input int w);
    logic [63:0] t;
    t = v & emask(w);
    if (w < 64 && t[w-1]) t = t | ~emask(w);
    return longint'(t);
  endfunction

  // External negation unit: negate each element whose top-chunk bit is set.
  function automatic logic [63:0] neg_fn(input logic [63:0] v, input logic [3:0] s,
                                         input logic [7:0] chg);
    int w, cpe;
    logic [63:0] r;
    w = sew_w(s);
    r = v;
    if (w != 0) begin
      cpe = w / 8;
      for (int e = 0; e < 64 / w; e++)
        if (chg[e*cpe + cpe - 1]) r = put_e(r, e, w, ~get_e(v, e, w) + 64'd1);
    end
    return r;
  endfunction

  // External unsigned divider arithmetic, divisor 0 gives all-ones / dividend.
  function automatic logic [63:0] udiv(input logic [63:0] a, input logic [63:0] b,
                                       input logic [3:0] s, input logic rem);
    int w;
    logic [63:0] r, ua, ub, q, m;
    w = sew_w(s);
    r = 64'd0;
    for (int e = 0; e < 64 / w; e++) begin
      ua = get_e(a, e, w);
      ub = get_e(b, e, w);
      if (ub == 64'd0) begin q = emask(w); m = ua; end
      else begin q = ua / ub; m = ua % ub; end
      r = put_e(r, e, w, rem ? m : q);
    end
    return r;
  endfunction

  assign neg_result = neg_fn(neg_opA, neg_sew, neg_change);
  assign div_ready  = div_ready_en;
  assign div_done   = mdl_done | force_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy <= 1'b0; mdl_done <= 1'b0; mdl_cnt <= 0;
      mdl_res <= 64'd0; div_result <= 64'd0;
    end else begin
      mdl_done <= 1'b0;
      if (div_valid && div_ready) begin
        hs_cnt <= hs_cnt + 1;
        hs_a <= div_a; hs_b <= div_b; hs_sew <= div_sew; hs_rem <= div_rem;
        if (div_dly <= 1) begin
          mdl_done   <= 1'b1;
          div_result <= udiv(div_a, div_b, div_sew, div_rem);
        end else begin
          mdl_busy <= 1'b1;
          mdl_cnt  <= div_dly - 1;
          mdl_res  <= udiv(div_a, div_b, div_sew, div_rem);
        end
      end else if (mdl_busy) begin
        if (mdl_cnt == 1) begin
          mdl_done   <= 1'b1;
          div_result <= mdl_res;
          mdl_busy   <= 1'b0;
        end
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (neg_change != 8'd0) neg_cyc <= neg_cyc + 1;
    if (div_valid) dv_cyc <= dv_cyc + 1;
  end

  // Signed reference: per-element DIV/REM with the divide-by-zero and overflow rules.
  task automatic ref_model(input logic op, input logic [3:0] s, input logic [63:0] a,
                           input logic [63:0] b, output logic [63:0] res,
                           output logic [63:0] da, output logic [63:0] db, output int negs);
    int w;
    longint sa, sb, q, r, minv;
    bit any_a, any_b, any_r;
    w = sew_w(s);
    res = 64'd0; da = 64'd0; db = 64'd0;
    any_a = 0; any_b = 0; any_r = 0;
    minv = sext(64'd1 << (w - 1), w);
    for (int e = 0; e < 64 / w; e++) begin
      sa = sext(get_e(a, e, w), w);
      sb = sext(get_e(b, e, w), w);
      if (sb == 0) begin q = -1; r = sa; end
      else if (sa == minv && sb == -1) begin q = minv; r = 0; end
      else begin q = sa / sb; r = sa % sb; end
      res = put_e(res, e, w, op ? 64'(r) : 64'(q));
      da  = put_e(da, e, w, (sa < 0) ? 64'(-sa) : 64'(sa));
      db  = put_e(db, e, w, (sb < 0) ? 64'(-sb) : 64'(sb));
      any_a |= (sa < 0);
      any_b |= (sb < 0);
      any_r |= op ? (sa < 0) : (((sa < 0) != (sb < 0)) && sb != 0);
    end
    negs = int'(any_a) + int'(any_b) + int'(any_r);
  endtask

  task automatic run_op(input logic op, input logic [3:0] s, input logic [63:0] a,
                        input logic [63:0] b, input int dly, input int rdy_hold,
                        input int out_hold);
    logic [63:0] ed, eda, edb;
    logic [63:0] snap_a, snap_b, snap_d;
    logic [3:0]  snap_s;
    logic        snap_r, err;
    int negs, n, k, hs0, neg0, dv0, exp_lat, exp_dv;
    err = !$onehot(s);
    ed = 64'd0; eda = 64'd0; edb = 64'd0; negs = 0;
    if (!err) ref_model(op, s, a, b, ed, eda, edb, negs);
    exp_lat = err ? 0 : 1 + dly + negs;
    exp_dv  = err ? 0 : 1 + rdy_hold;
    div_dly = dly;
    div_ready_en = (rdy_hold == 0);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL in_ready_idle got=%b exp=1", in_ready); end
    in_valid = 1'b1; in_op = op; in_sew = s; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    hs0 = hs_cnt; neg0 = neg_cyc; dv0 = dv_cyc; n = 0;
    if (rdy_hold > 0 && !err) begin
      k = 0;
      do begin @(negedge clk); k++; end while (div_valid !== 1'b1 && k < 50);
      snap_a = div_a; snap_b = div_b; snap_s = div_sew; snap_r = div_rem;
      for (int i = 0; i < rdy_hold; i++) begin
        @(negedge clk);
        total++;
        if ({div_valid, div_a, div_b, div_sew, div_rem} !== {1'b1, snap_a, snap_b, snap_s, snap_r}) begin
          bad++;
          $display("FAIL div_stable cyc=%0d valid=%b a=%h b=%h exp a=%h b=%h", i, div_valid, div_a, div_b, snap_a, snap_b);
        end
      end
      div_ready_en = 1'b1;
    end
    while (out_valid !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL out_timeout got out_valid=%b after %0d cycles exp=1", out_valid, n);
      return;
    end
    if (rdy_hold == 0) begin
      total++;
      if (n != exp_lat) begin bad++; $display("FAIL latency got=%0d exp=%0d", n, exp_lat); end
    end
    total++;
    if (out_data !== ed) begin bad++; $display("FAIL out_data got=%h exp=%h", out_data, ed); end
    total++;
    if (out_err !== err) begin bad++; $display("FAIL out_err got=%b exp=%b", out_err, err); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL in_ready_busy got=%b exp=0", in_ready); end
    total++;
    if (neg_cyc - neg0 != negs) begin bad++; $display("FAIL neg_passes got=%0d exp=%0d", neg_cyc - neg0, negs); end
    total++;
    if (dv_cyc - dv0 != exp_dv) begin bad++; $display("FAIL div_valid_cycles got=%0d exp=%0d", dv_cyc - dv0, exp_dv); end
    if (!err) begin
      total++;
      if ({hs_cnt - hs0, hs_a, hs_b, hs_sew, hs_rem} !== {32'd1, eda, edb, s, op}) begin
        bad++;
        $display("FAIL div_operands got n=%0d a=%h b=%h sew=%b rem=%b exp a=%h b=%h sew=%b rem=%b",
                 hs_cnt - hs0, hs_a, hs_b, hs_sew, hs_rem, eda, edb, s, op);
      end
    end
    last_data = out_data;
    snap_d = out_data;
    for (int i = 0; i < out_hold; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_data, out_err} !== {1'b1, snap_d, err}) begin
        bad++;
        $display("FAIL out_stable cyc=%0d valid=%b data=%h err=%b exp data=%h", i, out_valid, out_data, out_err, snap_d);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL in_ready_xfer got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL after_xfer got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({in_ready, out_valid, div_valid, neg_change, out_data, out_err} !== {1'b1, 1'b0, 1'b0, 8'd0, 64'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got in_ready=%b out_valid=%b div_valid=%b chg=%h data=%h err=%b",
               in_ready, out_valid, div_valid, neg_change, out_data, out_err);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_small_neg;
    run_op(1'b0, 4'b1000, 64'h0100_0100_0100_01F9, 64'h0101_0101_0101_0102, 2, 0, 0);
    total++;
    if (last_data[7:0] !== 8'hFD) begin bad++; $display("FAIL div8_elem0 got=%h exp=fd", last_data[7:0]); end
    run_op(1'b1, 4'b1000, 64'h0100_0100_0100_01F9, 64'h0101_0101_0101_0102, 1, 0, 0);
    total++;
    if (last_data[7:0] !== 8'hFF) begin bad++; $display("FAIL rem8_elem0 got=%h exp=ff", last_data[7:0]); end
  endtask

  task automatic test_all_skipped;
    run_op(1'b0, 4'b0001, 64'd100, 64'd7, 3, 0, 0);
    total++;
    if (last_data !== 64'd14) begin bad++; $display("FAIL div64 got=%0d exp=14", last_data); end
  endtask

  task automatic test_overflow_divzero;
    run_op(1'b0, 4'b0100, 64'h0003_0005_0007_8000, 64'h0001_0002_0003_FFFF, 2, 0, 0);
    total++;
    if (last_data[15:0] !== 16'h8000) begin bad++; $display("FAIL ovf_div got=%h exp=8000", last_data[15:0]); end
    run_op(1'b1, 4'b0100, 64'h0003_0005_0007_8000, 64'h0001_0002_0003_FFFF, 2, 0, 0);
    total++;
    if (last_data[15:0] !== 16'h0000) begin bad++; $display("FAIL ovf_rem got=%h exp=0000", last_data[15:0]); end
    run_op(1'b0, 4'b0010, 64'h0000_000C_FFFF_FFF6, 64'h0000_0005_0000_0000, 1, 0, 0);
    total++;
    if (last_data[31:0] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_div got=%h exp=ffffffff", last_data[31:0]); end
    run_op(1'b1, 4'b0010, 64'h0000_000C_FFFF_FFF6, 64'h0000_0005_0000_0000, 1, 0, 0);
    total++;
    if (last_data[31:0] !== 32'hFFFF_FFF6) begin bad++; $display("FAIL dz_rem got=%h exp=fffffff6", last_data[31:0]); end
  endtask

  task automatic test_bad_sew;
    run_op(1'b0, 4'b0011, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1, 0, 2);
    run_op(1'b1, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1, 0, 0);
  endtask

  task automatic test_backpressure;
    run_op(1'b0, 4'b1000, 64'h80F0_7F01_FF10_9C64, 64'hFF03_F900_02FD_0707, 4, 5, 3);
    run_op(1'b1, 4'b0001, 64'd1000, 64'd33, 2, 5, 3);
  endtask

  task automatic test_reset_mid_op;
    int k;
    div_dly = 20; div_ready_en = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; in_sew = 4'b1000;
    in_a = 64'h0102_0304_0506_07F9; in_b = 64'h0101_0101_0101_0102;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (div_valid !== 1'b1 && k < 30) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, div_valid} !== 3'b100) begin
      bad++;
      $display("FAIL mid_reset got in_ready=%b out_valid=%b div_valid=%b exp 1/0/0", in_ready, out_valid, div_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); force_done = 1'b1;
    @(negedge clk); force_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({in_ready, out_valid} !== 2'b10) begin
        bad++;
        $display("FAIL stray_done cyc=%0d got in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid);
      end
    end
    run_op(1'b0, 4'b1000, 64'h0102_0304_0506_07F9, 64'h0101_0101_0101_0102, 2, 0, 0);
  endtask

  function automatic logic [63:0] rnd_operand(input logic [3:0] s);
    int w;
    logic [63:0] v;
    w = sew_w(s);
    v = {$urandom, $urandom};
    for (int e = 0; e < 64 / w; e++) begin
      case ($urandom_range(0, 7))
        0: v = put_e(v, e, w, 64'd0);
        1: v = put_e(v, e, w, emask(w));
        2: v = put_e(v, e, w, 64'd1 << (w - 1));
        3: v = put_e(v, e, w, 64'($urandom_range(0, 9)));
        default: v = v;
      endcase
    end
    return v;
  endfunction

  task automatic test_random;
    logic [3:0] s;
    for (int i = 0; i < 60; i++) begin
      s = 4'b0001 << $urandom_range(0, 3);
      run_op(1'($urandom_range(0, 1)), s, rnd_operand(s), rnd_operand(s),
             $urandom_range(1, 6), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
             $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset;
    test_small_neg;
    test_all_skipped;
    test_overflow_divzero;
    test_bad_sew;
    test_backpressure;
    test_reset_mid_op;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
